// File: rtl/alu_pkg.sv
// Shared definitions for the serial-ALU command front-end: op codes, FSM states
// and the helper that packs captured result bytes into a 16-bit response word.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_SEND_M = 3'd2,
        ST_SEND_Q = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CAP1   = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    // mul and div return two bytes; add and sub return one
    function automatic logic is_two_byte(input op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // mul: product high then low; div: remainder then quotient
    function automatic logic [15:0] pack_result(input op_t op,
                                                input logic [7:0] byte0,
                                                input logic [7:0] byte1);
        if (is_two_byte(op)) begin
            return {byte0, byte1};
        end
        return {8'h00, byte0};
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command front-end for the byte-serial ALU: takes one op per cmd handshake,
// clears the ALU, streams M then Q, collects the result and returns it on rsp.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    // cmd and rsp use valid/ready: a transfer happens on a rising edge where
    // both are high; the producer holds its payload stable until that edge.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        alu_rst_b,
    output logic        alu_start,
    output logic [1:0]  alu_s,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_finish,
    input  logic        alu_overflow,
    output state_t      dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state;
    state_t state_next;

    op_t        op_q;
    op_t        op_next;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] byte0_q;
    logic       ovf_q;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic timed_out;

    // registered outputs and their next values
    logic        clr_n_q;
    logic        clr_n_d;
    logic        cmd_ready_d;
    logic        alu_start_d;
    logic [1:0]  alu_s_d;
    logic [7:0]  alu_inbus_d;
    logic        rsp_valid_d;
    logic [15:0] rsp_data_d;
    logic        rsp_ovf_d;
    logic        rsp_err_d;

    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign timed_out = (cnt == CNT_LAST);
    assign op_next   = accept ? op_t'(cmd_op) : op_q;
    assign alu_rst_b = rst_b & clr_n_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (cmd_valid) state_next = ST_CLR;
            ST_CLR:    state_next = ST_SEND_M;
            ST_SEND_M: state_next = ST_SEND_Q;
            ST_SEND_Q: state_next = ST_WAIT;
            ST_WAIT: begin
                // finish takes priority over a simultaneous timeout
                if (alu_finish) begin
                    state_next = is_two_byte(op_q) ? ST_CAP1 : ST_RESP;
                end else if (timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_CAP1:   state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d = (state_next == ST_IDLE);
        clr_n_d     = (state_next != ST_CLR);
        alu_start_d = (state_next == ST_SEND_M);
        rsp_valid_d = (state_next == ST_RESP);
        alu_s_d     = 2'b00;
        if ((state_next == ST_CLR) || (state_next == ST_SEND_M) ||
            (state_next == ST_SEND_Q) || (state_next == ST_WAIT) ||
            (state_next == ST_CAP1)) begin
            alu_s_d = op_next;
        end
        alu_inbus_d = 8'h00;
        if (state_next == ST_SEND_M) begin
            alu_inbus_d = a_q;
        end else if (state_next == ST_SEND_Q) begin
            alu_inbus_d = b_q;
        end
        rsp_data_d = rsp_data;
        rsp_ovf_d  = rsp_ovf;
        rsp_err_d  = rsp_err;
        if (state == ST_WAIT) begin
            if (alu_finish) begin
                if (!is_two_byte(op_q)) begin
                    rsp_data_d = pack_result(op_q, alu_outbus, 8'h00);
                    rsp_ovf_d  = alu_overflow;
                    rsp_err_d  = 1'b0;
                end
            end else if (timed_out) begin
                rsp_data_d = 16'h0000;
                rsp_ovf_d  = 1'b0;
                rsp_err_d  = 1'b1;
            end
        end else if (state == ST_CAP1) begin
            rsp_data_d = pack_result(op_q, byte0_q, alu_outbus);
            rsp_ovf_d  = ovf_q;
            rsp_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd_ready <= 1'b1;
            clr_n_q   <= 1'b1;
            alu_start <= 1'b0;
            alu_s     <= 2'b00;
            alu_inbus <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_d;
            clr_n_q   <= clr_n_d;
            alu_start <= alu_start_d;
            alu_s     <= alu_s_d;
            alu_inbus <= alu_inbus_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_ovf   <= rsp_ovf_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q    <= OP_ADD;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            byte0_q <= 8'h00;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                op_q <= op_t'(cmd_op);
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end
            if ((state == ST_WAIT) && alu_finish) begin
                byte0_q <= alu_outbus;
                ovf_q   <= alu_overflow;
            end
            // saturating wait counter
            if (state == ST_SEND_Q) begin
                cnt <= '0;
            end else if ((state == ST_WAIT) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural serial ALU, a command driver and a
// response monitor that checks each response against a queue of expectations.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] at;
        logic        err;
        logic        ovf;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        alu_rst_b;
    logic        alu_start;
    logic [1:0]  alu_s;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_finish;
    logic        alu_overflow;
    state_t      dbg_state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    alu_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_rst_b(alu_rst_b), .alu_start(alu_start), .alu_s(alu_s),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus),
        .alu_finish(alu_finish), .alu_overflow(alu_overflow),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // behavioural serial ALU, updated on the falling edge
    int         m_phase = 0;
    int         m_cnt = 0;
    int         m_dly = 0;
    bit         m_fin_en = 1'b1;
    logic [7:0] m_m, m_q, m_b0, m_b1;
    logic       m_ov;
    int         m_p;

    always @(negedge clk) begin
        if (!alu_rst_b) begin
            m_phase = 0;
            alu_finish = 1'b0;
            alu_outbus = 8'h00;
            alu_overflow = 1'b0;
        end else begin
            case (m_phase)
                0: if (alu_start) begin
                    m_m = alu_inbus;
                    m_phase = 1;
                end
                1: begin
                    m_q = alu_inbus;
                    m_b1 = 8'h00;
                    m_ov = 1'b0;
                    case (alu_s)
                        2'b00: begin
                            m_b0 = m_m + m_q;
                            m_ov = (m_m[7] == m_q[7]) && (m_b0[7] != m_m[7]);
                        end
                        2'b01: begin
                            m_b0 = m_m - m_q;
                            m_ov = (m_m[7] != m_q[7]) && (m_b0[7] != m_m[7]);
                        end
                        2'b10: begin
                            m_p = int'($signed(m_m)) * int'($signed(m_q));
                            m_b0 = m_p[15:8];
                            m_b1 = m_p[7:0];
                        end
                        default: begin
                            m_b0 = m_q % m_m;
                            m_b1 = m_q / m_m;
                        end
                    endcase
                    m_cnt = m_dly;
                    m_phase = 2;
                end
                2: if (m_fin_en) begin
                    if (m_cnt == 0) begin
                        alu_finish = 1'b1;
                        alu_outbus = m_b0;
                        alu_overflow = m_ov;
                        m_phase = 3;
                    end else begin
                        m_cnt--;
                    end
                end
                3: begin
                    alu_finish = 1'b0;
                    alu_outbus = m_b1;
                    alu_overflow = 1'b0;
                    m_phase = 4;
                end
                default: ;
            endcase
        end
    end

    // response monitor / scoreboard
    bit          seen = 1'b0;
    logic [15:0] held_data;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_b) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                held_data = rsp_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc), e.at);
                end
            end else begin
                chk("hold_data", 32'(rsp_data), 32'(held_data));
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            if (rsp_ready) seen = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_flags"}, 32'({rsp_ovf, rsp_err}), 32'd0);
        chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        chk({tag, "_alu_s"}, 32'(alu_s), 32'd0);
        chk({tag, "_alu_inbus"}, 32'(alu_inbus), 32'd0);
        chk({tag, "_alu_rst_b"}, 32'(alu_rst_b), 32'(rst_b));
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // driver: issue one command, check the ALU-side sequence, wait for completion
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int dly, input bit fin_en,
                          input logic [15:0] d, input logic ov, input logic er,
                          input int lat, input int stall, input bit rst_mid);
        int n;
        int acc;
        exp_t x;
        @(negedge clk);
        m_dly = dly;
        m_fin_en = fin_en;
        rsp_ready = (stall == 0);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        acc = cyc + 1;
        if (!rst_mid) begin
            x.at = 32'(acc + lat);
            x.err = er;
            x.ovf = ov;
            x.data = d;
            exp_q.push_back(x);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("clr_alu_rst_b", 32'(alu_rst_b), 32'd0);
        chk("clr_alu_s", 32'(alu_s), 32'(op));
        chk("clr_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("send_m_start", 32'(alu_start), 32'd1);
        chk("send_m_inbus", 32'(alu_inbus), 32'(a));
        @(negedge clk);
        chk("send_q_start", 32'(alu_start), 32'd0);
        chk("send_q_inbus", 32'(alu_inbus), 32'(b));
        chk("send_q_alu_rst_b", 32'(alu_rst_b), 32'd1);
        if (rst_mid) begin
            repeat (2) @(negedge clk);
            #2 rst_b = 1'b0;
            #1 check_reset_outputs("mid_reset");
            repeat (2) @(negedge clk);
            #2 rst_b = 1'b1;
            return;
        end
        if (stall > 0) begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            repeat (stall) @(negedge clk);
            #1 rsp_ready = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("op_done", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_b = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_a = 8'h00;
        cmd_b = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_b = 1'b1;

        //     op     a      b      dly fin d         ov    er    lat st rst
        run_op(2'b00, 8'd57,  8'd67,  0, 1, 16'h007C, 1'b0, 1'b0, 4, 0, 0);
        run_op(2'b00, 8'd127, 8'd126, 0, 1, 16'h00FD, 1'b1, 1'b0, 4, 0, 0);
        run_op(2'b01, 8'd10,  8'd3,   1, 1, 16'h0007, 1'b0, 1'b0, 5, 0, 0);
        run_op(2'b01, 8'h80,  8'h01,  0, 1, 16'h007F, 1'b1, 1'b0, 4, 0, 0);
        run_op(2'b10, 8'hA3,  8'h8D,  0, 1, 16'h29C7, 1'b0, 1'b0, 5, 0, 0);
        run_op(2'b10, 8'h59,  8'h9F,  2, 1, 16'hDE47, 1'b0, 1'b0, 7, 0, 0);
        run_op(2'b11, 8'd13,  8'd217, 0, 1, 16'h0910, 1'b0, 1'b0, 5, 0, 0);
        run_op(2'b11, 8'd12,  8'd247, 3, 1, 16'h0714, 1'b0, 1'b0, 8, 0, 0);
        // finish never arrives: error response after TO wait cycles
        run_op(2'b00, 8'd5,   8'd6,   0, 0, 16'h0000, 1'b0, 1'b1, 11, 0, 0);
        // finish on the last permitted wait cycle still wins
        run_op(2'b00, 8'd1,   8'd2,   7, 1, 16'h0003, 1'b0, 1'b0, 11, 0, 0);
        // response held off for 5 cycles
        run_op(2'b10, 8'd2,   8'd3,   0, 1, 16'h0006, 1'b0, 1'b0, 5, 5, 0);
        // reset during WAIT, then a normal op
        run_op(2'b11, 8'd1,   8'd2,   0, 0, 16'h0000, 1'b0, 1'b0, 0, 0, 1);
        run_op(2'b00, 8'd1,   8'd1,   0, 1, 16'h0002, 1'b0, 1'b0, 4, 0, 0);

        repeat (10) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Upstream command front-end for the serial 8-bit ALU (add/sub/mul/div). Accepts one operation per valid/ready handshake, clears the ALU, streams M then Q over the shared 8-bit operand bus, and waits for `finish`. It then collects the one- or two-byte result from `outbus` and returns a packed 16-bit response with overflow and timeout flags. It lets a host or bus bridge drive the ALU without knowing its byte-serial protocol.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before the operation is abandoned; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `cmd_a` in 8: M operand.
- `cmd_b` in 8: Q operand.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out 16: packed result.
- `rsp_ovf` out 1: ALU overflow.
- `rsp_err` out 1: timeout.
- `alu_rst_b` out 1: ALU reset, equal to `rst_b & clr_n_q`.
- `alu_start` out 1: ALU start pulse.
- `alu_s` out 2: ALU operation select.
- `alu_inbus` out 8: operand byte to ALU.
- `alu_outbus` in 8: result byte from ALU.
- `alu_finish` in 1: ALU done.
- `alu_overflow` in 1: ALU overflow flag.

## Operation
- States: IDLE, CLR, SEND_M, SEND_Q, WAIT, CAP1, RESP.
- All ALU-side and response outputs are registered; there are no combinational paths from inputs to outputs.
- **IDLE:** `cmd_ready=1`. On `cmd_valid&cmd_ready`, latch op/a/b and go to CLR.
- **CLR:** `clr_n_q=0` for one cycle, so `alu_rst_b` is low. Go to SEND_M.
- **SEND_M:** `alu_start=1`, `alu_inbus=a`. Go to SEND_Q.
- **SEND_Q:** `alu_start=0`, `alu_inbus=b`. Clear the timeout counter and go to WAIT.
- **`alu_s`:** holds the latched op from CLR through CAP1. It is 0 in IDLE.
- **`alu_inbus`:** 0 outside the SEND states.
- **WAIT:** count cycles.
  - On `alu_finish=1`, capture `alu_outbus` as byte0 and `alu_overflow` as the ovf flag.
  - If `op[1]=1`, go to CAP1; otherwise go to RESP.
  - If the counter reaches TIMEOUT-1 with no finish, go to RESP with `rsp_err=1`, `rsp_data=0`, `rsp_ovf=0`.
- **CAP1:** capture `alu_outbus` as byte1 unconditionally. Go to RESP.
- **Packing of `rsp_data`:**
  - add/sub: `{8'h00, byte0}`.
  - mul: `{byte0, byte1}`, i.e. product high then low.
  - div: `{byte0, byte1}`, i.e. remainder then quotient.
- **RESP:** `rsp_valid=1`. Data and flags stay stable until `rsp_ready=1`, then go to IDLE.
- `alu_finish` is ignored outside WAIT.
- The timeout counter is `$clog2(TIMEOUT)` bits wide and saturates; it does not wrap.

## Timing
- Reset values:
  - state IDLE, `cmd_ready=1`;
  - `rsp_valid`, `rsp_data`, `rsp_ovf`, `rsp_err` = 0;
  - `alu_start=0`, `alu_s=0`, `alu_inbus=0`;
  - `clr_n_q=1`, so `alu_rst_b` follows `rst_b`.
- Accept edge at cycle k: CLR in k+1, SEND_M in k+2, SEND_Q in k+3, WAIT from k+4.
- Add/sub with finish in the first WAIT cycle: `rsp_valid` high from cycle k+5.
- Mul/div with finish in the first WAIT cycle: `rsp_valid` high from cycle k+6.
- `rsp_valid&rsp_ready` in cycle n: `cmd_ready` is high in n+1. Back-to-back throughput is therefore one op per 6+ cycles.
- Reset mid-operation:
  - asynchronously returns the block to IDLE and drops the latched command;
  - `alu_rst_b` drops together with `rst_b`;
  - no response is produced for the aborted op.
- `rsp_ready` high outside RESP has no effect.
- Finish and timeout in the same WAIT cycle: finish wins, `rsp_err=0`.

## Structure
- Shared package `alu_pkg`:
  - op encodings `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_DIV`;
  - the state enumeration;
  - the result packing helper function.
- Single module; no sub-module is needed. The timeout counter is inline.

## Test plan
- Add M=57, Q=67 against the ALU → `rsp_data=0x007C`, ovf=0, err=0; `alu_start` high exactly one cycle with `inbus=57`, then `inbus=67`.
- Add M=127, Q=126 → `rsp_data=0x00FD`, `rsp_ovf=1`.
- Mul M=-93 (0xA3), Q=-115 (0x8D) → `rsp_data=0x29C7`. Mul M=0x59, Q=0x9F → `rsp_data=0xDE47`.
- Div M=13, Q=217 → `rsp_data=0x0910`. Div M=12, Q=247 → `rsp_data=0x0714`.
- ALU model with `finish` tied low, TIMEOUT=8 → `rsp_err=1`, `rsp_data=0` exactly 8 WAIT cycles after SEND_Q.
- Hold `rsp_ready=0` for 5 cycles → `rsp_valid`/`rsp_data` stable and `cmd_ready=0`. Separately, assert `rst_b` low during WAIT → all outputs at reset values, no response, next command completes normally.
